wordle_scorer: RTL and testbench

Scores one completed five-letter guess against the secret word and produces per-letter Wordle colours (green/yellow/gray) with correct duplicate-letter handling. It sits directly downstream of the guess-collection state machine: it consumes the 40-bit assembled guess and the 40-bit secret word at the end of each guess, and feeds the display and win/lose logic. Scoring is sequential: one green pass and one yellow pass of five cycles each, followed by a single-cycle done pulse.

---
 rtl/wordle_pkg.sv | 30 +++
 rtl/wordle_scorer_if.sv | 33 +++
 rtl/wordle_letter_pool.sv | 33 +++
 rtl/wordle_scorer.sv | 140 ++++++++++++++
 tb/tb_wordle_scorer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Shared constants, types and letter helpers for the Wordle scoring slice.
package wordle_pkg;
    localparam int         WORD_LEN    = 5;
    localparam int         LETTER_W    = 8;
    localparam int         NUM_LETTERS = 26;
    localparam logic [7:0] LETTER_A    = 8'h41;
    localparam logic [7:0] LETTER_Z    = 8'h5A;

    typedef enum logic [1:0] {
        GRAY   = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } colour_t;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_GREEN  = 2'd1;
    localparam state_t S_YELLOW = 2'd2;
    localparam state_t S_DONE   = 2'd3;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= LETTER_A) && (c <= LETTER_Z);
    endfunction

    function automatic logic [4:0] letter_idx(input logic [7:0] c);
        logic [7:0] d;
        d = c - LETTER_A;
        return d[4:0];
    endfunction
endpackage

// File: rtl/wordle_scorer_if.sv
// Request/result bundle between guess collection and the scorer.
// WORDLE_LETTER_STATUS_EN adds the new_game / letter_status pair.
interface wordle_scorer_if;
    logic                                                start;
    logic [wordle_pkg::WORD_LEN*wordle_pkg::LETTER_W-1:0] guess;
    logic [wordle_pkg::WORD_LEN*wordle_pkg::LETTER_W-1:0] secret;
    logic                                                busy;
    logic                                                done;
    logic [2*wordle_pkg::WORD_LEN-1:0]                   score;
    logic                                                win;
`ifdef WORDLE_LETTER_STATUS_EN
    logic                                                new_game;
    logic [2*wordle_pkg::NUM_LETTERS-1:0]                letter_status;
`endif

    modport master (
        output start, guess, secret,
`ifdef WORDLE_LETTER_STATUS_EN
        output new_game,
        input  letter_status,
`endif
        input  busy, done, score, win
    );

    modport slave (
        input  start, guess, secret,
`ifdef WORDLE_LETTER_STATUS_EN
        input  new_game,
        output letter_status,
`endif
        output busy, done, score, win
    );
endinterface

// File: rtl/wordle_letter_pool.sv
// 26 three-bit counters of unmatched secret letters, one inc and one dec port.
module wordle_letter_pool
    import wordle_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic [4:0] i_inc_idx,
    input  logic       i_dec,
    input  logic [4:0] i_dec_idx,
    input  logic [4:0] i_rd_idx,
    output logic [2:0] o_count
);
    logic [NUM_LETTERS-1:0][2:0] r_cnt;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LETTERS; i++) begin
                if (i_inc && i_inc_idx == 5'(i))
                    r_cnt[i] <= r_cnt[i] + 3'd1;
                else if (i_dec && i_dec_idx == 5'(i))
                    r_cnt[i] <= r_cnt[i] - 3'd1;
            end
        end
    end

    assign o_count = (i_rd_idx < 5'(NUM_LETTERS)) ? r_cnt[i_rd_idx] : 3'd0;
endmodule

// File: rtl/wordle_scorer.sv
// Sequential Wordle scorer: five-cycle green pass, five-cycle yellow pass, done pulse.
// WORDLE_LETTER_STATUS_EN adds the per-letter best-colour table.
module wordle_scorer
    import wordle_pkg::*;
(
    input  logic            Clk,
    input  logic            reset,
    wordle_scorer_if.slave  bus
);
    state_t      r_state;
    logic [2:0]  r_idx;
    logic [39:0] r_guess;
    logic [39:0] r_secret;
    logic [4:0]  r_green;
    logic [9:0]  r_score;
    logic        r_win;

    logic [7:0]  w_gl, w_sl;
    logic        w_start, w_last, w_match, w_yel, w_inc, w_dec;
    logic [2:0]  w_cnt;
    logic [1:0]  w_col;

    function automatic logic [7:0] letter_at(input logic [39:0] w, input logic [2:0] i);
        logic [7:0] l;
        case (i)
            3'd0:    l = w[39:32];
            3'd1:    l = w[31:24];
            3'd2:    l = w[23:16];
            3'd3:    l = w[15:8];
            3'd4:    l = w[7:0];
            default: l = 8'h00;
        endcase
        return l;
    endfunction

    always_comb begin
        w_start = (r_state == S_IDLE) && bus.start;
        w_last  = (r_idx == 3'd4);
        w_gl    = letter_at(r_guess, r_idx);
        w_sl    = letter_at(r_secret, r_idx);
        // Non-letters never match, so two identical invalid bytes stay gray.
        w_match = (w_gl == w_sl) && is_letter(w_gl);
        w_inc   = (r_state == S_GREEN) && !w_match && is_letter(w_sl);
        w_yel   = !r_green[r_idx] && is_letter(w_gl) && (w_cnt != 3'd0);
        w_dec   = (r_state == S_YELLOW) && w_yel;
        w_col   = r_green[r_idx] ? GREEN : (w_yel ? YELLOW : GRAY);
    end

    wordle_letter_pool u_pool (
        .Clk       (Clk),
        .reset     (reset),
        .i_clr     (w_start),
        .i_inc     (w_inc),
        .i_inc_idx (letter_idx(w_sl)),
        .i_dec     (w_dec),
        .i_dec_idx (letter_idx(w_gl)),
        .i_rd_idx  (letter_idx(w_gl)),
        .o_count   (w_cnt)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_guess  <= '0;
            r_secret <= '0;
            r_green  <= '0;
            r_score  <= '0;
            r_win    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_guess  <= bus.guess;
                    r_secret <= bus.secret;
                    r_green  <= '0;
                    r_score  <= '0;
                    r_win    <= 1'b0;
                    r_idx    <= 3'd0;
                    r_state  <= S_GREEN;
                end
                S_GREEN: begin
                    if (w_match) r_green[r_idx] <= 1'b1;
                    r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                    if (w_last) r_state <= S_YELLOW;
                end
                S_YELLOW: begin
                    r_score[2*(4-int'(r_idx)) +: 2] <= w_col;
                    r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                    // All-green mask is equivalent to score == 2AA; ready by the done cycle.
                    if (w_last) begin
                        r_win   <= &r_green;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.score = r_score;
    assign bus.win   = r_win;

`ifdef WORDLE_LETTER_STATUS_EN
    logic [51:0] r_status;
    logic [51:0] w_status_nxt;
    logic [7:0]  w_sl_l;
    logic [4:0]  w_sl_i;
    logic [1:0]  w_sc, w_code;

    // Status codes rank gray < yellow < green, so a plain max merges repeats.
    always_comb begin
        w_status_nxt = r_status;
        w_sl_l = 8'h00;
        w_sl_i = 5'd0;
        w_sc   = 2'b00;
        w_code = 2'b00;
        for (int p = 0; p < WORD_LEN; p++) begin
            w_sl_l = letter_at(r_guess, 3'(p));
            w_sl_i = letter_idx(w_sl_l);
            w_sc   = r_score[2*(4-p) +: 2];
            w_code = (w_sc == GREEN) ? 2'b11 : ((w_sc == YELLOW) ? 2'b10 : 2'b01);
            if (is_letter(w_sl_l) && (w_code > w_status_nxt[2*int'(w_sl_i) +: 2]))
                w_status_nxt[2*int'(w_sl_i) +: 2] = w_code;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            r_status <= '0;
        else if (bus.new_game)
            r_status <= '0;
        else if (r_state == S_DONE)
            r_status <= w_status_nxt;
    end

    assign bus.letter_status = r_status;
`endif
endmodule

// File: tb/tb_wordle_scorer.sv
// Self-checking bench for wordle_scorer: directed Wordle cases plus random words
// compared against a game-rule reference model.
module tb_wordle_scorer;
    logic Clk = 1'b0;
    logic reset;
    always #5 Clk = ~Clk;

    wordle_scorer_if bus();
    wordle_scorer dut (.Clk(Clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int st_model[26];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit valid_l(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    // Two-pass Wordle rule: exact hits first, then leftovers of the secret feed yellows.
    function automatic logic [9:0] ref_score(input logic [39:0] s, input logic [39:0] g);
        logic [7:0] sl[5];
        logic [7:0] gl[5];
        int         left[26];
        bit         hit[5];
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 26; i++) left[i] = 0;
        for (int i = 0; i < 5; i++) begin
            sl[i] = s[39-8*i -: 8];
            gl[i] = g[39-8*i -: 8];
            hit[i] = (sl[i] == gl[i]) && valid_l(gl[i]);
            if (!hit[i] && valid_l(sl[i])) left[int'(sl[i]) - 65]++;
        end
        for (int i = 0; i < 5; i++) begin
            if (hit[i]) r[9-2*i -: 2] = 2'b10;
            else if (valid_l(gl[i]) && left[int'(gl[i]) - 65] > 0) begin
                r[9-2*i -: 2] = 2'b01;
                left[int'(gl[i]) - 65]--;
            end
        end
        return r;
    endfunction

    task automatic model_update(input logic [39:0] s, input logic [39:0] g);
        logic [9:0] sc;
        logic [7:0] l;
        int c;
        sc = ref_score(s, g);
        for (int i = 0; i < 5; i++) begin
            l = g[39-8*i -: 8];
            if (valid_l(l)) begin
                c = (sc[9-2*i -: 2] == 2'b10) ? 3 : ((sc[9-2*i -: 2] == 2'b01) ? 2 : 1);
                if (c > st_model[int'(l) - 65]) st_model[int'(l) - 65] = c;
            end
        end
    endtask

    function automatic logic [51:0] model_packed();
        logic [51:0] v;
        v = '0;
        for (int i = 0; i < 26; i++) v[2*i +: 2] = 2'(st_model[i]);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 26; i++) st_model[i] = 0;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = (bus.done === 1'b1);
        end
    endtask

    task automatic run_score(input logic [39:0] s, input logic [39:0] g, input string nm);
        logic [9:0] exp;
        int  n;
        bit  seen;
        exp = ref_score(s, g);
        bus.secret = s;
        bus.guess  = g;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b expected 1", nm, bus.busy);
        end
        wait_done(n, seen);
        checks++;
        if (!seen || n != 10) begin
            failures++;
            $display("FAIL %s done_latency: got seen=%0b edges=%0d expected edges=10", nm, seen, n);
        end
        checks++;
        if (bus.score !== exp) begin
            failures++;
            $display("FAIL %s score: got %h expected %h", nm, bus.score, exp);
        end
        checks++;
        if (bus.win !== (exp == 10'h2AA)) begin
            failures++;
            $display("FAIL %s win: got %b expected %b", nm, bus.win, exp == 10'h2AA);
        end
        model_update(s, g);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s single_done: got done=%b busy=%b expected 0 0", nm, bus.done, bus.busy);
        end
`ifdef WORDLE_LETTER_STATUS_EN
        checks++;
        if (bus.letter_status !== model_packed()) begin
            failures++;
            $display("FAIL %s letter_status: got %h expected %h", nm, bus.letter_status, model_packed());
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.score !== 10'h000 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL reset_result: got score=%h win=%b expected 000 0", bus.score, bus.win);
        end
`ifdef WORDLE_LETTER_STATUS_EN
        checks++;
        if (bus.letter_status !== 52'h0) begin
            failures++;
            $display("FAIL reset_status: got %h expected 0", bus.letter_status);
        end
`endif
        model_clear();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_score("ROBOT", "ROBOT", "robot_robot");
        checks++;
        if (bus.score !== 10'h2AA || bus.win !== 1'b1) begin
            failures++;
            $display("FAIL all_green: got score=%h win=%b expected 2aa 1", bus.score, bus.win);
        end
        run_score("ROBOT", "OTTER", "robot_otter");
        checks++;
        if (bus.score !== 10'h141) begin
            failures++;
            $display("FAIL otter_const: got %h expected 141", bus.score);
        end
        run_score("ABBOT", "BOBBY", "abbot_bobby");
        checks++;
        if (bus.score !== 10'h160) begin
            failures++;
            $display("FAIL bobby_const: got %h expected 160", bus.score);
        end
    endtask

    task automatic test_invalid_letter();
        logic [39:0] s, g;
        s = {"VI", 8'h00, "ID"};
        g = {"DI", 8'h00, "IV"};
        run_score(s, g, "invalid_byte");
        checks++;
        if (bus.score[5:4] !== 2'b00) begin
            failures++;
            $display("FAIL invalid_pos2: got %b expected 00", bus.score[5:4]);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        bit seen;
        bus.secret = "ROBOT";
        bus.guess  = "OTTER";
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        bus.secret = "ROBOT";
        bus.guess  = "ROBOT";
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(n, seen);
        checks++;
        if (!seen || n != 7) begin
            failures++;
            $display("FAIL ignore_start_latency: got seen=%0b edges=%0d expected edges=7", seen, n);
        end
        checks++;
        if (bus.score !== 10'h141 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_score: got score=%h win=%b expected 141 0", bus.score, bus.win);
        end
        model_update("ROBOT", "OTTER");
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        logic [9:0] exp_b;
        exp_b = ref_score("CRANE", "NACRE");
        bus.secret = "ABBOT";
        bus.guess  = "BOBBY";
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(n, seen);
        checks++;
        if (!seen || bus.score !== 10'h160) begin
            failures++;
            $display("FAIL b2b_first: got seen=%0b score=%h expected 1 160", seen, bus.score);
        end
        model_update("ABBOT", "BOBBY");
        bus.secret = "CRANE";
        bus.guess  = "NACRE";
        bus.start  = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start_in_done: got busy=%b expected 0", bus.busy);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.score !== 10'h000 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b score=%h win=%b expected 1 000 0", bus.busy, bus.score, bus.win);
        end
        wait_done(n, seen);
        checks++;
        if (!seen || n != 10 || bus.score !== exp_b) begin
            failures++;
            $display("FAIL b2b_second: got seen=%0b edges=%0d score=%h expected 1 10 %h", seen, n, bus.score, exp_b);
        end
        model_update("CRANE", "NACRE");
        tick();
    endtask

    task automatic test_reset_mid();
        int ndone;
        bus.secret = "ROBOT";
        bus.guess  = "ROBOT";
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.score !== 10'h000 || bus.win !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b score=%h win=%b expected 0 000 0", bus.busy, bus.score, bus.win);
        end
        model_clear();
        tick();
        reset = 1'b0;
        ndone = 0;
        repeat (14) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || bus.score !== 10'h000) begin
            failures++;
            $display("FAIL reset_mid_no_done: got done_pulses=%0d score=%h expected 0 000", ndone, bus.score);
        end
    endtask

    function automatic logic [7:0] rand_letter();
        if ($urandom_range(0, 15) == 0) return 8'($urandom_range(0, 255));
        return 8'h41 + 8'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        logic [39:0] s, g;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 5; i++) begin
                s[39-8*i -: 8] = rand_letter();
                g[39-8*i -: 8] = rand_letter();
            end
            if (it % 7 == 0) g = s;
            run_score(s, g, $sformatf("random_%0d", it));
        end
    endtask

`ifdef WORDLE_LETTER_STATUS_EN
    task automatic test_letter_status();
        int n;
        bit seen;
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        model_clear();
        checks++;
        if (bus.letter_status !== 52'h0) begin
            failures++;
            $display("FAIL new_game_clear: got %h expected 0", bus.letter_status);
        end
        run_score("ROBOT", "OTTER", "status_otter");
        checks++;
        if (bus.letter_status[29:28] !== 2'b10 || bus.letter_status[39:38] !== 2'b10 ||
            bus.letter_status[9:8] !== 2'b01 || bus.letter_status[35:34] !== 2'b10) begin
            failures++;
            $display("FAIL status_otter_letters: got O=%b T=%b E=%b R=%b expected 10 10 01 10",
                     bus.letter_status[29:28], bus.letter_status[39:38],
                     bus.letter_status[9:8], bus.letter_status[35:34]);
        end
        run_score("ROBOT", "ROBOT", "status_robot");
        checks++;
        if (bus.letter_status[35:34] !== 2'b11 || bus.letter_status[29:28] !== 2'b11 ||
            bus.letter_status[3:2] !== 2'b11 || bus.letter_status[39:38] !== 2'b11) begin
            failures++;
            $display("FAIL status_robot_letters: got R=%b O=%b B=%b T=%b expected 11 11 11 11",
                     bus.letter_status[35:34], bus.letter_status[29:28],
                     bus.letter_status[3:2], bus.letter_status[39:38]);
        end
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        model_clear();
        checks++;
        if (bus.letter_status !== 52'h0) begin
            failures++;
            $display("FAIL new_game_after_play: got %h expected 0", bus.letter_status);
        end
        bus.secret = "CRANE";
        bus.guess  = "CRANE";
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        wait_done(n, seen);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        checks++;
        if (!seen || bus.letter_status !== 52'h0) begin
            failures++;
            $display("FAIL new_game_beats_done: got seen=%0b status=%h expected 1 0", seen, bus.letter_status);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.guess  = '0;
        bus.secret = '0;
`ifdef WORDLE_LETTER_STATUS_EN
        bus.new_game = 1'b0;
`endif
        model_clear();
        repeat (2) tick();
        test_reset();
        test_basic();
        test_invalid_letter();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WORDLE_LETTER_STATUS_EN
        test_letter_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
